// File: rtl/ocs_slot_sched.sv
// Slot scheduler: derives slot boundaries from corrected local time, produces
// the guard/data windows, and supervises lock against periodic time sync.
module ocs_slot_sched #(
  parameter int P_SLOT_LEN_LOG2 = 10,
  parameter int P_GUARD_LEN     = 64,
  parameter int P_SYNC_PERIOD   = 16
) (
  input  logic        i_clk,
  input  logic        i_rst_n,
  input  logic        i_stat_rx_status,
  input  logic        i_syn_done,
  input  logic [63:0] i_local_time,
  output logic        o_new_slot_start,
  output logic        o_slot_id,
  output logic        o_guard,
  output logic        o_data_window,
  output logic        o_syn_req,
  output logic        o_time_jump,
  output logic        o_locked
);

  localparam int L = P_SLOT_LEN_LOG2;
  localparam logic [L-1:0] GUARD_PH = L'(P_GUARD_LEN);
  localparam logic [15:0]  SYNC_1X  = 16'(P_SYNC_PERIOD);
  localparam logic [15:0]  SYNC_2X  = 16'(2 * P_SYNC_PERIOD);

  typedef enum logic [1:0] {
    S_IDLE       = 2'd0,
    S_WAIT_ALIGN = 2'd1,
    S_GUARD      = 2'd2,
    S_DATA       = 2'd3
  } state_t;

  state_t       state, state_n;
  logic [15:0]  sn, sn_d, sn_inc;
  logic [15:0]  cnt, cnt_n, cnt_inc;
  logic [L-1:0] ph;
  logic         first, boundary, jump;
  logic         start_n, slot_id_n, req_n, jump_n;
  logic         unused_hi;

  assign sn        = i_local_time[L+15:L];
  assign ph        = i_local_time[L-1:0];
  assign unused_hi = ^i_local_time[63:L+16];
  assign sn_inc    = sn_d + 16'd1;
  assign cnt_inc   = cnt + 16'd1;
  // No history exists in the first cycle after reset, so no boundary then.
  assign boundary  = !first && (sn != sn_d);
  // Any boundary that is not the next slot in sequence (forward or backward).
  assign jump      = boundary && (sn != sn_inc);

  // Slot-number history register.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      sn_d  <= '0;
      first <= 1'b1;
    end else begin
      sn_d  <= sn;
      first <= 1'b0;
    end
  end

  // State register, slot counter and registered outputs.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state            <= S_IDLE;
      cnt              <= '0;
      o_new_slot_start <= 1'b0;
      o_slot_id        <= 1'b0;
      o_syn_req        <= 1'b0;
      o_time_jump      <= 1'b0;
      o_guard          <= 1'b0;
      o_data_window    <= 1'b0;
      o_locked         <= 1'b0;
    end else begin
      state            <= state_n;
      cnt              <= cnt_n;
      o_new_slot_start <= start_n;
      o_slot_id        <= slot_id_n;
      o_syn_req        <= req_n;
      o_time_jump      <= jump_n;
      o_guard          <= (state_n == S_GUARD);
      o_data_window    <= (state_n == S_DATA);
      o_locked         <= (state_n == S_GUARD) || (state_n == S_DATA);
    end
  end

  // Next state, counter update and pulse generation.
  always_comb begin
    state_n   = state;
    cnt_n     = cnt;
    start_n   = 1'b0;
    slot_id_n = o_slot_id;
    req_n     = 1'b0;
    jump_n    = 1'b0;
    if (!i_stat_rx_status) begin
      state_n = S_IDLE;
    end else begin
      case (state)
        S_IDLE: begin
          if (i_syn_done) state_n = S_WAIT_ALIGN;
        end
        S_WAIT_ALIGN: begin
          // Lock on the first boundary; it is never reported as a jump.
          if (boundary) begin
            state_n   = S_GUARD;
            start_n   = 1'b1;
            slot_id_n = sn[0];
            cnt_n     = '0;
          end
        end
        S_GUARD, S_DATA: begin
          if (boundary) begin
            cnt_n  = cnt_inc;
            jump_n = jump;
            req_n  = (cnt_inc == SYNC_1X) || (cnt_inc == SYNC_2X);
            // A sync-done in the same cycle rescues the lock.
            if (cnt_inc == SYNC_2X && !i_syn_done) begin
              state_n = S_IDLE;
            end else begin
              state_n   = S_GUARD;
              start_n   = 1'b1;
              slot_id_n = sn[0];
            end
          end else if (state == S_GUARD && ph >= GUARD_PH) begin
            state_n = S_DATA;
          end
        end
        default: state_n = S_IDLE;
      endcase
    end
    // Boundary is accounted first, then the sync clears the count.
    if (i_syn_done) cnt_n = '0;
  end

endmodule

// File: tb/tb_ocs_slot_sched.sv
// Testbench for ocs_slot_sched: directed scenarios plus randomized time
// stimulus, checked against a behavioural slot/lock model.
module tb_ocs_slot_sched;

  localparam int SL = 10;
  localparam int GL = 64;
  localparam int SP = 16;

  logic        i_clk = 1'b0;
  logic        i_rst_n = 1'b0;
  logic        i_stat_rx_status = 1'b0;
  logic        i_syn_done = 1'b0;
  logic [63:0] i_local_time = '0;
  logic        o_new_slot_start, o_slot_id, o_guard, o_data_window;
  logic        o_syn_req, o_time_jump, o_locked;

  int n_cmp = 0;
  int n_fail = 0;

  // Behavioural model state
  bit          m_first, m_locked, m_armed, m_guard;
  bit          e_start, e_slot, e_req, e_jump;
  logic [15:0] m_prev_sn;
  int          m_cnt;

  ocs_slot_sched #(
    .P_SLOT_LEN_LOG2(SL),
    .P_GUARD_LEN(GL),
    .P_SYNC_PERIOD(SP)
  ) dut (
    .i_clk(i_clk),
    .i_rst_n(i_rst_n),
    .i_stat_rx_status(i_stat_rx_status),
    .i_syn_done(i_syn_done),
    .i_local_time(i_local_time),
    .o_new_slot_start(o_new_slot_start),
    .o_slot_id(o_slot_id),
    .o_guard(o_guard),
    .o_data_window(o_data_window),
    .o_syn_req(o_syn_req),
    .o_time_jump(o_time_jump),
    .o_locked(o_locked)
  );

  always #5 i_clk = ~i_clk;

  function automatic logic [6:0] outs();
    return {o_new_slot_start, o_slot_id, o_guard, o_data_window, o_syn_req, o_time_jump, o_locked};
  endfunction

  function automatic logic [6:0] expv();
    return {e_start, e_slot, m_guard, m_locked && !m_guard, e_req, e_jump, m_locked};
  endfunction

  task automatic model_reset();
    m_first = 1; m_locked = 0; m_armed = 0; m_guard = 0; m_cnt = 0; m_prev_sn = '0;
    e_start = 0; e_slot = 0; e_req = 0; e_jump = 0;
  endtask

  // One clock of the scheduler rules, from the inputs seen at that edge.
  task automatic model_step(input bit rx, input bit sd, input logic [63:0] t);
    logic [15:0] sn;
    int          ph;
    bit          bnd, jmp;
    sn  = t[SL+15:SL];
    ph  = int'(t[SL-1:0]);
    bnd = !m_first && (sn != m_prev_sn);
    jmp = bnd && (sn != 16'(m_prev_sn + 16'd1));
    m_first = 0; m_prev_sn = sn;
    e_start = 0; e_req = 0; e_jump = 0;
    if (!rx) begin
      m_locked = 0; m_armed = 0; m_guard = 0;
    end else if (m_locked) begin
      if (bnd) begin
        m_cnt++;
        e_req  = (m_cnt % SP == 0);
        e_jump = jmp;
        if (m_cnt >= 2 * SP && !sd) begin
          m_locked = 0; m_guard = 0;
        end else begin
          e_start = 1; e_slot = sn[0]; m_guard = 1;
        end
      end else if (m_guard && ph >= GL) begin
        m_guard = 0;
      end
    end else if (m_armed) begin
      if (bnd) begin
        m_armed = 0; m_locked = 1; m_guard = 1; m_cnt = 0; e_start = 1; e_slot = sn[0];
      end
    end else if (sd) begin
      m_armed = 1;
    end
    if (sd) m_cnt = 0;
  endtask

  task automatic tick(input bit rx, input bit sd, input logic [63:0] t);
    i_stat_rx_status = rx;
    i_syn_done       = sd;
    i_local_time     = t;
    @(posedge i_clk);
    model_step(rx, sd, t);
    #1;
  endtask

  task automatic reset_assert();
    i_rst_n = 1'b0;
    model_reset();
    repeat (2) @(posedge i_clk);
    #1;
  endtask

  task automatic reset_release();
    @(negedge i_clk);
    i_rst_n = 1'b1;
  endtask

  task automatic test_reset();
    reset_assert();
    n_cmp++;
    if (outs() !== 7'd0) begin n_fail++; $display("FAIL reset_state got=%b exp=%b", outs(), 7'd0); end
    reset_release();
    for (int i = 0; i < 5000; i++) begin
      tick(1'b1, 1'b0, 64'(66 + i));
      n_cmp++;
      if (outs() !== 7'd0) begin n_fail++; $display("FAIL idle_no_sync i=%0d got=%b exp=%b", i, outs(), 7'd0); end
    end
  endtask

  task automatic test_lock_free_run();
    int          n_start, n_req;
    logic [63:0] last;
    n_start = 0; n_req = 0; last = '0;
    reset_assert();
    reset_release();
    for (logic [63:0] t = 400; t <= 64'd33796; t++) begin
      tick(1'b1, t == 64'd500, t);
      n_cmp++;
      if (outs() !== expv()) begin n_fail++; $display("FAIL free_run_model t=%0d got=%b exp=%b", t, outs(), expv()); end
      if (t == 64'd1024) begin
        n_cmp++;
        if ({o_new_slot_start, o_slot_id, o_guard, o_locked} !== 4'b1111)
          begin n_fail++; $display("FAIL first_slot got=%b exp=1111", {o_new_slot_start, o_slot_id, o_guard, o_locked}); end
      end
      if (t >= 64'd1024 && t < 64'd2048) begin
        n_cmp++;
        if ({o_guard, o_data_window} !== ((t < 64'd1088) ? 2'b10 : 2'b01))
          begin n_fail++; $display("FAIL slot1_window t=%0d got=%b", t, {o_guard, o_data_window}); end
      end
      if (o_new_slot_start) begin
        n_start++;
        n_cmp++;
        if (o_slot_id !== t[SL] || (last != 0 && t - last != 64'd1024))
          begin n_fail++; $display("FAIL slot_cadence t=%0d last=%0d id=%b", t, last, o_slot_id); end
        last = t;
      end
      if (o_syn_req) begin
        n_req++;
        n_cmp++;
        if (t != 64'd17408 && t != 64'd33792) begin n_fail++; $display("FAIL syn_req_time got=%0d exp=17408/33792", t); end
      end
      if (t == 64'd33792) begin
        n_cmp++;
        if ({o_locked, o_new_slot_start, o_syn_req} !== 3'b001)
          begin n_fail++; $display("FAIL lock_loss got=%b exp=001", {o_locked, o_new_slot_start, o_syn_req}); end
      end
    end
    n_cmp++;
    if (n_start != 32 || n_req != 2) begin n_fail++; $display("FAIL pulse_counts got=%0d/%0d exp=32/2", n_start, n_req); end
  endtask

  task automatic test_jump();
    reset_assert();
    reset_release();
    for (logic [63:0] t = 400; t <= 64'd3000; t++) begin
      tick(1'b1, t == 64'd500, t);
      n_cmp++;
      if (outs() !== expv()) begin n_fail++; $display("FAIL jump_pre_model t=%0d got=%b exp=%b", t, outs(), expv()); end
    end
    tick(1'b1, 1'b0, 64'd5000);
    n_cmp++;
    if ({o_time_jump, o_new_slot_start, o_slot_id, o_guard} !== 4'b1101)
      begin n_fail++; $display("FAIL fwd_jump got=%b exp=1101", {o_time_jump, o_new_slot_start, o_slot_id, o_guard}); end
    tick(1'b1, 1'b0, 64'd5001);
    n_cmp++;
    if ({o_guard, o_data_window} !== 2'b01) begin n_fail++; $display("FAIL fwd_jump_guard got=%b exp=01", {o_guard, o_data_window}); end
    for (logic [63:0] t = 5002; t <= 64'd5125; t++) begin
      tick(1'b1, 1'b0, t);
      n_cmp++;
      if (outs() !== expv()) begin n_fail++; $display("FAIL jump_mid_model t=%0d got=%b exp=%b", t, outs(), expv()); end
    end
    tick(1'b1, 1'b0, 64'd5110);
    n_cmp++;
    if ({o_time_jump, o_new_slot_start, o_slot_id} !== 3'b110)
      begin n_fail++; $display("FAIL bwd_jump got=%b exp=110", {o_time_jump, o_new_slot_start, o_slot_id}); end
    n_cmp++;
    if (outs() !== expv()) begin n_fail++; $display("FAIL bwd_jump_model got=%b exp=%b", outs(), expv()); end
  endtask

  task automatic test_sync_keep();
    logic [63:0] b;
    bit          sd;
    reset_assert();
    reset_release();
    for (logic [63:0] t = 400; t <= 64'd1030; t++) tick(1'b1, t == 64'd500, t);
    // Each slot: boundary region, then skip ahead within the slot to its end.
    for (int s = 2; s <= 66; s++) begin
      b = 64'(s) * 64'd1024;
      for (logic [63:0] t = b - 4; t < b + 70; t++) begin
        sd = ((s % 10 == 0) && s <= 30 && t == b + 20) || (s == 62 && t == b);
        tick(1'b1, sd, t);
        n_cmp++;
        if (outs() !== expv() || o_locked !== 1'b1)
          begin n_fail++; $display("FAIL lock_held s=%0d t=%0d got=%b exp=%b", s, t, outs(), expv()); end
        if (s == 62 && t == b) begin
          n_cmp++;
          if ({o_new_slot_start, o_syn_req, o_locked} !== 3'b111)
            begin n_fail++; $display("FAIL sync_on_32nd got=%b exp=111", {o_new_slot_start, o_syn_req, o_locked}); end
        end
      end
    end
  endtask

  task automatic test_rx_drop();
    reset_assert();
    reset_release();
    for (logic [63:0] t = 400; t <= 64'd1200; t++) tick(1'b1, t == 64'd500, t);
    n_cmp++;
    if (o_data_window !== 1'b1) begin n_fail++; $display("FAIL pre_drop_data got=%b exp=1", o_data_window); end
    tick(1'b0, 1'b0, 64'd1201);
    n_cmp++;
    if ({o_locked, o_data_window, o_guard} !== 3'b000)
      begin n_fail++; $display("FAIL rx_drop got=%b exp=000", {o_locked, o_data_window, o_guard}); end
    for (logic [63:0] t = 1202; t <= 64'd2100; t++) begin
      tick(1'b1, 1'b0, t);
      n_cmp++;
      if (o_locked !== 1'b0 || outs() !== expv()) begin n_fail++; $display("FAIL rx_drop_idle t=%0d got=%b exp=%b", t, outs(), expv()); end
    end
  endtask

  task automatic test_async_reset();
    reset_assert();
    reset_release();
    for (logic [63:0] t = 400; t <= 64'd1030; t++) tick(1'b1, t == 64'd500, t);
    n_cmp++;
    if (o_guard !== 1'b1) begin n_fail++; $display("FAIL pre_reset_guard got=%b exp=1", o_guard); end
    #2;
    i_rst_n = 1'b0;
    #1;
    n_cmp++;
    if (outs() !== 7'd0) begin n_fail++; $display("FAIL async_reset got=%b exp=%b", outs(), 7'd0); end
    model_reset();
    reset_release();
  endtask

  task automatic test_random();
    logic [63:0] t;
    int          r;
    bit          sd, rx;
    reset_assert();
    reset_release();
    t = 64'd100000;
    for (int i = 0; i < 6000; i++) begin
      r = int'($urandom_range(0, 999));
      if (r < 900)      t = t + 64'd1;
      else if (r < 960) t = {t[63:SL], 10'h3fd};
      else if (r < 985) t = t + 64'($urandom_range(1, 4000));
      else              t = t - 64'($urandom_range(1, 3000));
      sd = ($urandom_range(0, 199) == 0);
      rx = ($urandom_range(0, 1499) != 0);
      tick(rx, sd, t);
      n_cmp++;
      if (outs() !== expv()) begin n_fail++; $display("FAIL random_model i=%0d t=%0d got=%b exp=%b", i, t, outs(), expv()); end
    end
  endtask

  initial begin
    model_reset();
    test_reset();
    test_lock_free_run();
    test_jump();
    test_sync_keep();
    test_rx_drop();
    test_async_reset();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog time limit reached");
    $fatal(1);
  end

endmodule
